// File: rtl/idct_pkg.sv
// Shared constants, FSM state type and the IDCT basis for idct8_serial.
package idct_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;
  localparam int ACC_W  = 35;

  typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

  // |C| magnitudes, round(32768*a(k)*cos(i*pi/16)); index 0 doubles as the DC term, 8 is zero
  function automatic logic [DATA_W-1:0] cos_mag(input logic [3:0] i);
    case (i)
      4'd0:    cos_mag = DATA_W'(11585);
      4'd1:    cos_mag = DATA_W'(16069);
      4'd2:    cos_mag = DATA_W'(15137);
      4'd3:    cos_mag = DATA_W'(13623);
      4'd4:    cos_mag = DATA_W'(11585);
      4'd5:    cos_mag = DATA_W'(9102);
      4'd6:    cos_mag = DATA_W'(6270);
      4'd7:    cos_mag = DATA_W'(3196);
      default: cos_mag = '0;
    endcase
  endfunction

  // Signed C[n][k]: fold (2n+1)k mod 32 into the first quadrant and track the cosine sign
  function automatic logic signed [DATA_W-1:0] coef(input logic [2:0] n, input logic [2:0] k);
    logic [4:0] m;
    logic [3:0] idx;
    logic       neg;
    m = 5'({n, 1'b1}) * 5'(k);
    if (k == 3'd0) begin
      idx = 4'd0; neg = 1'b0;
    end else if (m <= 5'd8) begin
      idx = m[3:0]; neg = 1'b0;
    end else if (m <= 5'd16) begin
      idx = 4'(5'd16 - m); neg = 1'b1;
    end else if (m <= 5'd24) begin
      idx = 4'(m - 5'd16); neg = 1'b1;
    end else begin
      idx = 4'(6'd32 - {1'b0, m}); neg = 1'b0;
    end
    coef = neg ? -signed'(cos_mag(idx)) : signed'(cos_mag(idx));
  endfunction

endpackage

// File: rtl/idct_mac.sv
// Signed DWxDW multiply into an AW-bit accumulator; exposes the next-sum so the
// final term can be folded straight into the output register.
module idct_mac #(
  parameter int DW = 16,
  parameter int AW = 35
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] sum
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc;

  assign prod = a * b;
  assign sum  = acc + AW'(prod);

  // accumulator: clear wins, otherwise add one full-precision term per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/idct8_serial.sv
// 8-point serial 1D IDCT, Q1.15 in/out, one shared MAC.
// Optional macro IDCT_ROUND_EN: round half up before the final shift (default floor).
module idct8_serial #(
  parameter int DATA_W = idct_pkg::DATA_W,
  parameter int FRAC_W = idct_pkg::FRAC_W,
  parameter int ACC_W  = idct_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  import idct_pkg::*;

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
`ifdef IDCT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (FRAC_W-1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  state_t                   state, nstate;
  logic [2:0]               k, n;
  logic [7:0][DATA_W-1:0]   xr;
  logic signed [ACC_W-1:0]  sum, rsum, shv;
  logic [DATA_W-1:0]        sat;
  logic                     in_hs, out_hs, mac_clr, mac_en;

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign mac_en   = (state == MAC);
  assign mac_clr  = (in_hs && k == 3'd7) || out_hs;

  idct_mac #(.DW(DATA_W), .AW(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (coef(n, k)),
    .b   (signed'(xr[k])),
    .sum (sum)
  );

  // scale the completed sum back to Q1.15 and clamp
  always_comb begin
    rsum = sum + RND;
    shv  = rsum >>> FRAC_W;
    sat  = DATA_W'(shv);
    if (shv > SMAX)      sat = DATA_W'(SMAX);
    else if (shv < SMIN) sat = DATA_W'(SMIN);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= nstate;
  end

  // next-state: 8 loads, then 8 MAC cycles per output, each output held until taken
  always_comb begin
    nstate = state;
    case (state)
      LOAD:    if (in_hs && k == 3'd7) nstate = MAC;
      MAC:     if (k == 3'd7)          nstate = OUT;
      OUT:     if (out_hs)             nstate = (n == 3'd7) ? LOAD : MAC;
      default:                         nstate = LOAD;
    endcase
  end

  // datapath: coefficient capture, k/n sequencing and the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr        <= '0;
      k         <= '0;
      n         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: if (in_hs) begin
          xr[k] <= in_data;
          k     <= k + 3'd1;
          n     <= '0;
        end
        MAC: begin
          k <= k + 3'd1;
          if (k == 3'd7) begin
            out_data  <= sat;
            out_valid <= 1'b1;
            out_last  <= (n == 3'd7);
          end
        end
        OUT: if (out_hs) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          n         <= n + 3'd1;
          k         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idct8_serial.sv
// Scoreboard bench for idct8_serial: real-valued cosine reference, decoupled monitor.
module tb_idct8_serial;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_last, busy;
  logic [15:0] out_data;

  idct8_serial dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] d; logic l; } exp_t;

  exp_t               q[$];
  int                 rise_q[$];
  int                 cyc = 0, checks = 0, errors = 0, pops = 0;
  bit                 rmode = 1'b0;
  logic signed [15:0] blk [8];
  logic               pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [15:0]        pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cf(int n, int k);
    real a, v;
    a = (k == 0) ? $sqrt(1.0/8.0) : 0.5;
    v = 32768.0 * a * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  // expected y[0..7] for the current blk
  task automatic model();
    for (int n = 0; n < 8; n++) begin
      longint s = 0;
      exp_t   e;
      for (int k = 0; k < 8; k++) s += longint'(cf(n, k)) * longint'(blk[k]);
`ifdef IDCT_ROUND_EN
      s += 16384;
`endif
      s = s >>> 15;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      e.d = 16'(s);
      e.l = (n == 7);
      q.push_back(e);
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rmode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(output int hs8);
    model();
    hs8 = 0;
    for (int i = 0; i < 8; i++) begin
      bit hs;
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = blk[i];
      do begin
        hs = in_ready;
        tick();
        t++;
      end while (!hs && t < 300);
      if (!hs) chk("input_handshake_timeout", 0, 1);
    end
    hs8 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin tick(); t++; end
    chk("drain_remaining", q.size(), 0);
    tick(); tick();
  endtask

  // monitor: scoreboard pops, hold stability, and valid rise times
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (!out_valid || out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL hold_stable actual v=%0b d=%0d l=%0b required v=1 d=%0d l=%0b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid && !pv) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        pops++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual %0d required none", $signed(out_data));
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL sample actual %0d last=%0b required %0d last=%0b",
                     $signed(out_data), out_last, $signed(e.d), e.l);
          end
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
  end

  initial begin
    int h, t;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;

    // DC impulse
    for (int i = 0; i < 8; i++) blk[i] = '0;
    blk[0] = 16'sd16384;
    send(h); drain();

    // first AC basis vector
    for (int i = 0; i < 8; i++) blk[i] = '0;
    blk[1] = 16'sd32767;
    send(h); drain();

    // full-scale input: saturation
    for (int i = 0; i < 8; i++) blk[i] = 16'sd32767;
    send(h); drain();

    // all-zero block with latency/throughput timing
    for (int i = 0; i < 8; i++) blk[i] = '0;
    rise_q.delete();
    send(h); drain();
    chk("rise_count", rise_q.size(), 8);
    if (rise_q.size() >= 2) begin
      chk("first_latency", rise_q[0] - h, 8);
      chk("sample_spacing", rise_q[1] - rise_q[0], 9);
    end

    // backpressure on y[3] with input attempts while busy
    for (int i = 0; i < 8; i++) blk[i] = 16'($urandom);
    pops = 0;
    send(h);
    t = 0;
    while (pops < 3 && t < 500) begin tick(); t++; end
    chk("reach_y3", pops, 3);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    chk("y3_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      chk("in_ready_while_busy", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset while computing y[2]
    for (int i = 0; i < 8; i++) blk[i] = 16'($urandom);
    pops = 0;
    send(h);
    t = 0;
    while (pops < 2 && t < 500) begin tick(); t++; end
    repeat (3) tick();
    rst = 1'b1;
    q.delete();
    tick(); tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    tick();
    for (int i = 0; i < 8; i++) blk[i] = 16'($urandom_range(0, 4095)) - 16'sd2048;
    send(h); drain();

    // randomized blocks with random backpressure
    rmode = 1'b1;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < 8; i++)
        blk[i] = (b % 3 == 0) ? 16'($urandom_range(0, 511)) - 16'sd256 : 16'($urandom);
      send(h); drain();
    end
    rmode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
